// File: rtl/ldpc_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_iter_ctrl
// Function : frame sequencer for the KxK LDPC PE array: load, VNU/CNU iterate,
//            read-out. Define LDPC_EARLY_TERM_EN for zero-syndrome termination.
// Revision : 1.0  initial release
// ============================================================================
module ldpc_iter_ctrl #(
    parameter int L            = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int K            = 6,
    parameter int ITER_WIDTH   = 5,
    parameter int MAX_ITER     = 16,
    parameter int CNU_PIPE_LAT = 5,
    parameter int DEC_LAT      = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ITER_WIDTH-1:0] max_iter_cfg,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [K-1:0]          column_select,
    output logic [ADDR_WIDTH-1:0] load_add,
    output logic                  en,
    output logic                  en_cnu,
    output logic [ADDR_WIDTH-1:0] phase_add,
    input  logic [3*K-1:0]        p_bit,
    input  logic                  p_bit_valid,
    output logic [ADDR_WIDTH-1:0] read_add,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic                  converged
);

    localparam int COL_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(L - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_DRAIN = ADDR_WIDTH'(CNU_PIPE_LAT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_FLUSH = ADDR_WIDTH'(DEC_LAT - 1);
    localparam logic [COL_W-1:0]      LAST_COL   = COL_W'(K - 1);
    localparam logic [ITER_WIDTH-1:0] DEF_LIMIT  = ITER_WIDTH'(MAX_ITER);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_VNU    = 4'd2,
        S_CNU    = 4'd3,
        S_DRAIN  = 4'd4,
        S_CHECK  = 4'd5,
        S_OUTPUT = 4'd6,
        S_FLUSH  = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t                  state_q, state_d;
    // cnt is shared: load address, phase address, drain/output/flush counter
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ITER_WIDTH-1:0]   lim_q, lim_d;
    logic [ITER_WIDTH-1:0]   iter_q, iter_d;
    logic [DEC_LAT-1:0]      vpipe_q, vpipe_d;
    logic [ITER_WIDTH:0]     w_iter_inc;
    logic                    w_et_exit;

    assign w_iter_inc = {1'b0, iter_q} + {{ITER_WIDTH{1'b0}}, 1'b1};

`ifdef LDPC_EARLY_TERM_EN
    logic syn_q, syn_d;
    logic conv_q, conv_d;

    always_comb begin
        syn_d  = syn_q;
        conv_d = conv_q;
        if (state_q == S_VNU && cnt_q == LAST_ADDR) begin
            syn_d = 1'b0;
        end else if (p_bit_valid && (state_q == S_CNU || state_q == S_DRAIN)) begin
            syn_d = syn_q | (|p_bit);
        end
        if (state_q == S_IDLE && start) begin
            conv_d = 1'b0;
        end else if (state_q == S_CHECK && !syn_q) begin
            conv_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            syn_q  <= 1'b0;
            conv_q <= 1'b0;
        end else begin
            syn_q  <= syn_d;
            conv_q <= conv_d;
        end
    end

    assign w_et_exit = ~syn_q;
    assign converged = conv_q;
`else
    logic w_unused_pbit;
    assign w_unused_pbit = ^{p_bit_valid, p_bit};
    assign w_et_exit     = 1'b0;
    assign converged     = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        col_d         = col_q;
        lim_d         = lim_q;
        iter_d        = iter_q;
        in_ready      = 1'b0;
        column_select = '0;
        load_add      = '0;
        en            = 1'b0;
        en_cnu        = 1'b0;
        phase_add     = '0;
        read_add      = '0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_LOAD;
                    lim_d   = (max_iter_cfg == '0) ? DEF_LIMIT : max_iter_cfg;
                    iter_d  = '0;
                    cnt_d   = '0;
                    col_d   = '0;
                end
            end
            S_LOAD: begin
                in_ready      = 1'b1;
                column_select = K'(1) << col_q;
                load_add      = cnt_q;
                if (in_valid) begin
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d = '0;
                        if (col_q == LAST_COL) begin
                            col_d   = '0;
                            state_d = S_VNU;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end
            S_VNU: begin
                en        = 1'b1;
                phase_add = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = S_CNU;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_CNU: begin
                en_cnu    = 1'b1;
                phase_add = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == LAST_DRAIN) begin
                    cnt_d   = '0;
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_CHECK: begin
                cnt_d  = '0;
                iter_d = (iter_q == '1) ? iter_q : w_iter_inc[ITER_WIDTH-1:0];
                if (w_et_exit || w_iter_inc == {1'b0, lim_q}) begin
                    state_d = S_OUTPUT;
                end else begin
                    state_d = S_VNU;
                end
            end
            S_OUTPUT: begin
                read_add = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_FLUSH: begin
                if (cnt_q == LAST_FLUSH) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Each issued read address emerges as out_valid DEC_LAT cycles later
    always_comb begin
        vpipe_d = (vpipe_q << 1) | DEC_LAT'(state_q == S_OUTPUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            col_q   <= '0;
            lim_q   <= '0;
            iter_q  <= '0;
            vpipe_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            lim_q   <= lim_d;
            iter_q  <= iter_d;
            vpipe_q <= vpipe_d;
        end
    end

    assign out_valid  = vpipe_q[DEC_LAT-1];
    assign iter_count = iter_q;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldpc_iter_ctrl
// Function : directed self-checking bench for ldpc_iter_ctrl (default parameters).
// Revision : 1.0  initial release
// ============================================================================
module tb_ldpc_iter_ctrl;

`ifdef LDPC_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  max_iter_cfg;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  column_select;
    logic [4:0]  load_add;
    logic        en;
    logic        en_cnu;
    logic [4:0]  phase_add;
    logic [17:0] p_bit;
    logic        p_bit_valid;
    logic [4:0]  read_add;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [4:0]  iter_count;
    logic        converged;

    int checks   = 0;
    int failures = 0;
    logic [4:0] ra_hist [0:4095];

    ldpc_iter_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .max_iter_cfg (max_iter_cfg),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .column_select(column_select),
        .load_add     (load_add),
        .en           (en),
        .en_cnu       (en_cnu),
        .phase_add    (phase_add),
        .p_bit        (p_bit),
        .p_bit_valid  (p_bit_valid),
        .read_add     (read_add),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done),
        .iter_count   (iter_count),
        .converged    (converged)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Caller is positioned 1 time unit after a rising edge; returns likewise.
    // mode: 0 p_bit zero, 1 p_bit[4] set during iteration 1 only, 2 p_bit nonzero.
    task automatic run_frame(input string nm, input logic [4:0] cfg, input bit toggle,
                             input int mode, input bit vnu_start,
                             input int exp_it, input bit exp_cv);
        int cyc = 0, fin = 0, done_cyc = -1;
        int nready = 0, beats = 0, lerr = 0, nen = 0, ncnu = 0, perr = 0, xerr = 0;
        int nov = 0, first_ov = -1, first_en = -1, nbusy = 0, raerr = 0;
        int load_end, exp_done;
        logic [4:0] it_at_done = '0;
        logic       cv_at_done = 1'b0, bz_at_done = 1'b1;
        load_end = toggle ? 383 : 192;
        exp_done = load_end + exp_it * 70 + 39;
        while (fin == 0 && cyc < 4000) begin
            start        = (cyc == 0) || (vnu_start && cyc == 400);
            max_iter_cfg = (cyc == 0) ? cfg : 5'd5;
            in_valid     = toggle ? cyc[0] : 1'b1;
            p_bit_valid  = 1'b1;
            p_bit        = (mode == 0) ? 18'h0 :
                           (mode == 1) ? ((cyc <= 262) ? 18'h00010 : 18'h0) : 18'h20401;
            @(negedge clk);
            if (in_ready) nready++;
            if (in_ready && in_valid) begin
                if (column_select !== (6'b1 << (beats / 32)) || load_add !== 5'(beats % 32)) lerr++;
                beats++;
            end
            if (en) begin
                if (first_en < 0) first_en = cyc;
                if (phase_add !== 5'(nen % 32)) perr++;
                nen++;
            end
            if (en_cnu) begin
                if (phase_add !== 5'(ncnu % 32)) perr++;
                ncnu++;
            end
            if ((en && en_cnu) || (en && in_ready) || (en_cnu && in_ready)) xerr++;
            if (out_valid) begin
                if (first_ov < 0) first_ov = cyc;
                nov++;
            end
            if (busy) nbusy++;
            ra_hist[cyc] = read_add;
            if (done) begin
                done_cyc   = cyc;
                it_at_done = iter_count;
                cv_at_done = converged;
                bz_at_done = busy;
                fin        = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check({nm, "_timeout"}, fin, 1);
        check({nm, "_done_cycle"}, done_cyc, exp_done);
        check({nm, "_in_ready_cycles"}, nready, load_end);
        check({nm, "_load_beats"}, beats, 192);
        check({nm, "_load_seq_err"}, lerr, 0);
        check({nm, "_first_en"}, first_en, load_end + 1);
        check({nm, "_en_cycles"}, nen, exp_it * 32);
        check({nm, "_en_cnu_cycles"}, ncnu, exp_it * 32);
        check({nm, "_phase_err"}, perr, 0);
        check({nm, "_exclusive_err"}, xerr, 0);
        check({nm, "_out_valid_cycles"}, nov, 32);
        check({nm, "_first_out_valid"}, first_ov, exp_done - 32);
        if (done_cyc >= 38) begin
            for (int i = 0; i < 32; i++)
                if (ra_hist[done_cyc - 38 + i] !== 5'(i)) raerr++;
        end else begin
            raerr = 1;
        end
        check({nm, "_read_add_err"}, raerr, 0);
        check({nm, "_busy_cycles"}, nbusy, exp_done - 1);
        check({nm, "_busy_at_done"}, bz_at_done, 0);
        check({nm, "_iter_count"}, it_at_done, exp_it);
        check({nm, "_converged"}, cv_at_done, exp_cv);
        // Status must hold in IDLE after the done pulse
        @(negedge clk);
        check({nm, "_done_pulse_len"}, done, 0);
        check({nm, "_iter_held"}, iter_count, exp_it);
        check({nm, "_conv_held"}, converged, exp_cv);
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; max_iter_cfg = '0; in_valid = 1'b0;
        p_bit = '0; p_bit_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {in_ready, column_select, load_add, en, en_cnu, phase_add,
                               read_add, out_valid, busy, done, iter_count, converged}, 0);
        @(posedge clk); #1;

        run_frame("f1_cfg3",     5'd3, 1'b0, 2, 1'b0, 3, 1'b0);
        run_frame("f2_pzero",    5'd3, 1'b0, 0, 1'b0, ET ? 1 : 3, ET);
        run_frame("f3_pbit4",    5'd3, 1'b0, 1, 1'b0, ET ? 2 : 3, ET);
        run_frame("f4_cfg0",     5'd0, 1'b0, 2, 1'b0, 16, 1'b0);
        run_frame("f5_toggle",   5'd1, 1'b1, 2, 1'b1, 1, 1'b0);

        // Reset asserted mid-CNU (CNU spans cycles 225..256 of this frame)
        start = 1'b1; max_iter_cfg = 5'd2; in_valid = 1'b1; p_bit = 18'h1; p_bit_valid = 1'b1;
        for (int c = 1; c <= 230; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("mid_cnu_en_cnu", en_cnu, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_en_cnu", en_cnu, 0);
        check("post_reset_busy", busy, 0);
        check("post_reset_outputs", {in_ready, column_select, load_add, en, phase_add,
                                     read_add, out_valid, done, iter_count, converged}, 0);
        @(posedge clk); #1;

        run_frame("f6_after_rst", 5'd2, 1'b0, 2, 1'b0, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ldpc_iter_ctrl.md
Name: ldpc_iter_ctrl

Overview:
Top-level sequencer for the K x K PE-block LDPC decoder array.
- Loads one frame of intrinsic data: drives column_select, load address and valid.
- Runs VNU/CNU iterations: drives the en and en_cnu phases and the phase address, and waits out the shuffle->CNU->unshuffle pipeline.
- Accumulates CNU parity bits for early termination, then sequences read-out of decoded words.
- Sits beside the PE array and replaces the hand-driven en/column_select/load_add_in/read_add_in stimulus.

Parameters:
L, 32, words per PE memory.
ADDR_WIDTH, 5, log2(L).
K, 6, PE array dimension; also the number of CNUs per layer.
ITER_WIDTH, 5, width of the iteration counter and configuration.
MAX_ITER, 16, iteration limit used when max_iter_cfg is 0.
CNU_PIPE_LAT, 5, cycles from the last en_cnu cycle to the last PE write-back.
DEC_LAT, 6, cycles from a read address to the matching decoded column (one per PE column).

Ports:
clk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous active-high reset.
start  in  1  one-cycle frame start; honoured only in IDLE.
max_iter_cfg  in  ITER_WIDTH  iteration limit, sampled on start; 0 selects MAX_ITER.
in_valid  in  1  intrinsic word valid.
in_ready  out  1  controller accepts intrinsic word.
column_select  out  K  one-hot target PE column during LOAD, else 0.
load_add  out  ADDR_WIDTH  intrinsic write address.
en  out  1  VNU phase enable for the PE array.
en_cnu  out  1  CNU phase enable.
phase_add  out  ADDR_WIDTH  address counter for the VNU/CNU phase.
p_bit  in  3*K  parity bits from all CNUs.
p_bit_valid  in  1  p_bit qualifier.
read_add  out  ADDR_WIDTH  decoded-memory read address.
out_valid  out  1  decoded column valid, DEC_LAT cycles after its read_add.
busy  out  1  high from the cycle after start until done.
done  out  1  one-cycle pulse at end of frame.
iter_count  out  ITER_WIDTH  iterations completed, held after done.
converged  out  1  frame ended on zero syndrome; held until next start.

Behaviour:
- States: IDLE, LOAD, VNU, CNU, DRAIN, CHECK, OUTPUT, FLUSH, DONE.
- Reset, from any state including mid-frame: state IDLE and all counters 0. Outputs in_ready, column_select, load_add, en, en_cnu, phase_add, read_add, out_valid, busy, done, iter_count and converged are all 0.
- IDLE:
  - start -> LOAD.
  - lim <= (max_iter_cfg == 0) ? MAX_ITER : max_iter_cfg.
  - iter_count <= 0; converged <= 0.
  - start outside IDLE is ignored.
- LOAD:
  - in_ready = 1; column_select = one-hot(col); load_add = addr.
  - Each in_valid beat increments addr. At addr = L-1, addr wraps to 0 and col increments.
  - The beat at col = K-1, addr = L-1 -> VNU. Total K*L beats.
  - in_valid low stalls the counters, with no timeout.
- VNU: en = 1 for L cycles; phase_add 0..L-1; -> CNU.
- CNU:
  - en_cnu = 1 for L cycles; phase_add 0..L-1.
  - The syndrome register is cleared on CNU entry.
  - syn |= |p_bit on each p_bit_valid cycle, in CNU and in DRAIN.
  - -> DRAIN.
- DRAIN: CNU_PIPE_LAT cycles with en and en_cnu both 0; -> CHECK.
- CHECK, single cycle: iter_count += 1.
  - If converged-by-syndrome (see Optional Feature) -> OUTPUT with converged <= 1.
  - Else if iter_count+1 == lim -> OUTPUT.
  - Else -> VNU.
  - One iteration is 2L + CNU_PIPE_LAT + 1 cycles; 70 at defaults.
- OUTPUT: read_add 0..L-1, one per cycle; -> FLUSH.
- FLUSH: DEC_LAT cycles; -> DONE.
- out_valid is a DEC_LAT-deep delay of "read_add issued". It produces exactly L valid cycles, starting DEC_LAT cycles after OUTPUT entry.
- DONE: done = 1 for one cycle; busy = 0; -> IDLE. The next start is honoured the cycle after DONE.
- Exclusivity: en, en_cnu and in_ready are never high in the same cycle.
- iter_count saturates at 2^ITER_WIDTH - 1. It cannot exceed lim because the limit check precedes any wrap.

Optional Feature:
LDPC_EARLY_TERM_EN
- Defined: CHECK exits to OUTPUT when syn == 0, setting converged = 1.
- Undefined: syn is not implemented, p_bit and p_bit_valid are ignored, and converged is tied to 0. Every frame runs exactly lim iterations.

Test Plan:
- Reset, then idle: all outputs 0. Assert start with max_iter_cfg = 3 and continuous in_valid -> in_ready high exactly 192 cycles. column_select steps 000001 -> 100000 every 32 beats and load_add wraps 31->0.
- Early termination off (LDPC_EARLY_TERM_EN undefined), frame as above -> 3 iterations of 70 cycles. done pulses at load + 210 + 32 + 6 + 1 cycles; iter_count = 3; converged = 0.
- Early termination on, p_bit = 0 with p_bit_valid throughout -> CHECK exits after iteration 1; iter_count = 1; converged = 1. Repeat with p_bit[4] = 1 in iteration 1 only -> exit after iteration 2.
- max_iter_cfg = 0 with nonzero p_bit -> 16 iterations; iter_count = 16.
- in_valid toggling 1-0 during LOAD -> load_add advances only on valid beats; 192 beats total. start pulsed during VNU -> ignored, no state change.
- reset asserted mid-CNU -> next cycle en_cnu = 0, busy = 0, state IDLE. A following start -> a complete normal frame with correct counts.
